// File: rtl/axi4_lite_fanout_rd.sv
// AXI4-Lite read fanout: routes each read to one of two slaves by address and returns R beats in issue order.
// Define AXI4_LITE_FANOUT_RD_R_REG_EN to register the R path through a 2-entry skid buffer.

module axi4_lite_fanout_rd #(
    parameter int           A = 32,
    parameter int           N = 4,
    parameter logic [A-1:0] M = A'(32'h8000_0000),
    parameter int           D = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [A-1:0]          s_araddr,
    input  logic [2:0]            s_arprot,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [8*N-1:0]        s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [1:0][A-1:0]     m_araddr,
    output logic [1:0][2:0]       m_arprot,
    output logic [1:0]            m_arvalid,
    input  logic [1:0]            m_arready,
    input  logic [1:0][8*N-1:0]   m_rdata,
    input  logic [1:0][1:0]       m_rresp,
    input  logic [1:0]            m_rvalid,
    output logic [1:0]            m_rready
);

    localparam int CW = $clog2(D) + 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LO    = 4'b0010,
        HI    = 4'b0100,
        FLUSH = 4'b1000
    } state_t;

    state_t          state, next_state;
    logic            full, hold_lo;
    logic [A-1:0]    hold_addr;
    logic [2:0]      hold_prot;
    logic [CW-1:0]   cnt;
    logic            sel_q, sel;
    logic            s_ar_hs, ar_hs, r_hs, drained, issue_ok;

    assign s_arready = ~full & ~areset;
    assign s_ar_hs   = s_arvalid & s_arready;
    assign ar_hs     = |(m_arvalid & m_arready);
    assign r_hs      = s_rvalid & s_rready;
    // AR issue can never coincide with reaching zero, so only the R side matters here
    assign drained   = (cnt - CW'(r_hs)) == '0;
    assign issue_ok  = full & ~areset & (cnt < CW'(D));

    assign m_araddr = {hold_addr, hold_addr};
    assign m_arprot = {hold_prot, hold_prot};

    always_comb begin
        sel = sel_q;
        if (state == LO) sel = 1'b0;
        else if (state == HI) sel = 1'b1;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (full) next_state = hold_lo ? LO : HI;
            LO, HI: begin
                if (full) begin
                    if (hold_lo != (state == LO)) next_state = FLUSH;
                end else if (drained) begin
                    next_state = IDLE;
                end
            end
            FLUSH:   if (drained) next_state = full ? (hold_lo ? LO : HI) : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_arvalid    = '0;
        m_arvalid[0] = issue_ok & (next_state == LO);
        m_arvalid[1] = issue_ok & (next_state == HI);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            cnt   <= '0;
            full  <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            state <= next_state;
            sel_q <= sel;
            if (s_ar_hs) full <= 1'b1;
            else if (ar_hs) full <= 1'b0;
            case ({ar_hs, r_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (s_ar_hs) begin
            hold_addr <= s_araddr;
            hold_prot <= s_arprot;
            hold_lo   <= (s_araddr < M);
        end
    end

`ifdef AXI4_LITE_FANOUT_RD_R_REG_EN
    logic [1:0][8*N-1:0] buf_data;
    logic [1:0][1:0]     buf_resp;
    logic                wr_ptr, rd_ptr;
    logic [1:0]          buf_cnt;
    logic                buf_accept, push, pop;

    // only accept beats for reads still owed by a slave, so stray responses are refused
    assign buf_accept = ~areset & (buf_cnt != 2'd2) & (CW'(buf_cnt) < cnt);
    assign push       = m_rvalid[sel] & buf_accept;
    assign pop        = s_rvalid & s_rready;
    assign s_rvalid   = ~areset & (buf_cnt != 2'd0);
    assign s_rdata    = buf_data[rd_ptr];
    assign s_rresp    = buf_resp[rd_ptr];

    always_comb begin
        m_rready      = '0;
        m_rready[sel] = buf_accept;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            buf_data[wr_ptr] <= m_rdata[sel];
            buf_resp[wr_ptr] <= m_rresp[sel];
        end
    end
`else
    logic live;

    // with nothing outstanding the selected port is closed, so stray beats are refused
    assign live     = ~areset & (cnt != '0);
    assign s_rvalid = live & m_rvalid[sel];
    assign s_rdata  = m_rdata[sel];
    assign s_rresp  = m_rresp[sel];

    always_comb begin
        m_rready      = '0;
        m_rready[sel] = live & s_rready;
    end
`endif

endmodule

// File: tb/tb_axi4_lite_fanout_rd.sv
// Self-checking bench for axi4_lite_fanout_rd: slave models on both ports, scoreboard of expected R beats.

module tb_axi4_lite_fanout_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          port;
    } vec_t;

    logic              aclk;
    logic              areset;
    logic [31:0]       s_araddr;
    logic [2:0]        s_arprot;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [1:0][31:0]  m_araddr;
    logic [1:0][2:0]   m_arprot;
    logic [1:0]        m_arvalid;
    logic [1:0]        m_arready;
    logic [1:0][31:0]  m_rdata;
    logic [1:0][1:0]   m_rresp;
    logic [1:0]        m_rvalid;
    logic [1:0]        m_rready;

    axi4_lite_fanout_rd dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_araddr  (s_araddr),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          passCount = 0;
    int          checkCount = 0;
    int          cyc = 0;
    req_t        reqQ[$];
    req_t        expQ[$];
    logic [31:0] slvAddr[2][16];
    int          slvTime[2][16];
    int          slvHead[2];
    int          slvTail[2];
    int          rDelay[2];
    int          arCount[2];
    int          lastMArCyc[2];
    int          arRDone[2];
    int          lastSArCyc = 0;
    int          rDone = 0;
    logic [1:0]  arReadyEn;
    logic        sReadyEn;
    logic        sawFlush;

    // bench slave response: port tag in the upper half, address bits below
    function automatic logic [31:0] slaveData(logic [31:0] addr, int port);
        return (port == 1 ? 32'h5A5A_0000 : 32'hA5A5_0000) | {20'h0, addr[15:4]};
    endfunction

    function automatic req_t modelReq(logic [31:0] addr);
        req_t r;
        int   port;
        port   = (addr < 32'h8000_0000) ? 0 : 1;
        r.addr = addr;
        r.data = slaveData(addr, port);
        r.resp = addr[3:2];
        return r;
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic failNow(string name);
        checkCount++;
        $display("[TB] FAIL %s actual=timeout required=completion", name);
    endtask

    task automatic applyStimulus();
        s_arvalid = (reqQ.size() > 0);
        s_araddr  = (reqQ.size() > 0) ? reqQ[0].addr : 32'h0;
        s_arprot  = 3'b010;
        s_rready  = sReadyEn;
        for (int j = 0; j < 2; j++) begin
            m_arready[j] = arReadyEn[j];
            if (slvHead[j] != slvTail[j] && (cyc - slvTime[j][slvHead[j] & 15]) >= rDelay[j]) begin
                m_rvalid[j] = 1'b1;
                m_rdata[j]  = slaveData(slvAddr[j][slvHead[j] & 15], j);
                m_rresp[j]  = slvAddr[j][slvHead[j] & 15][3:2];
            end else begin
                m_rvalid[j] = 1'b0;
                m_rdata[j]  = 32'h0;
                m_rresp[j]  = 2'b00;
            end
        end
    endtask

    task automatic sampleHandshakes();
        req_t e;
        if (s_rvalid && s_rready) begin
            rDone++;
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL rUnexpected actual=beat %0h required=no beat", s_rdata);
            end else begin
                e = expQ.pop_front();
                checkOutput("rBeat", {30'h0, s_rresp, s_rdata}, {30'h0, e.resp, e.data});
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (m_rvalid[j] && m_rready[j]) slvHead[j]++;
            if (m_arvalid[j] && m_arready[j]) begin
                slvAddr[j][slvTail[j] & 15] = m_araddr[j];
                slvTime[j][slvTail[j] & 15] = cyc;
                slvTail[j]++;
                arCount[j]++;
                lastMArCyc[j] = cyc;
                arRDone[j]    = rDone;
            end
        end
        if (4'(dut.state) == 4'b1000) sawFlush = 1'b1;
        if (s_arvalid && s_arready) begin
            expQ.push_back(reqQ.pop_front());
            lastSArCyc = cyc;
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        applyStimulus();
        #3;
        sampleHandshakes();
    endtask

    task automatic waitIdle(string name, int budget);
        int n = 0;
        while (!(reqQ.size() == 0 && expQ.size() == 0 && slvHead[0] == slvTail[0] &&
                 slvHead[1] == slvTail[1]) && n < budget) begin
            tick();
            n++;
        end
        if (!(reqQ.size() == 0 && expQ.size() == 0)) failNow(name);
    endtask

    task automatic resetBench();
        reqQ.delete();
        expQ.delete();
        for (int j = 0; j < 2; j++) slvHead[j] = slvTail[j];
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   d0, d1, doneBefore;
        logic seen;

        vecs[0] = '{32'h0000_0010, 32'hA5A5_0001, 2'd0, 0};
        vecs[1] = '{32'h8000_0004, 32'h5A5A_0000, 2'd1, 1};
        vecs[2] = '{32'h7FFF_FFFC, 32'hA5A5_0FFF, 2'd3, 0};
        vecs[3] = '{32'h8000_0000, 32'h5A5A_0000, 2'd0, 1};
        vecs[4] = '{32'hFFFF_FFF8, 32'h5A5A_0FFF, 2'd2, 1};
        vecs[5] = '{32'h0000_0000, 32'hA5A5_0000, 2'd0, 0};
        vecs[6] = '{32'h0000_1234, 32'hA5A5_0123, 2'd1, 0};

        for (int j = 0; j < 2; j++) begin
            slvHead[j] = 0; slvTail[j] = 0; rDelay[j] = 1;
            arCount[j] = 0; lastMArCyc[j] = 0; arRDone[j] = 0;
        end
        arReadyEn = 2'b11;
        sReadyEn  = 1'b1;
        sawFlush  = 1'b0;
        areset    = 1'b1;
        s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0; s_rready = 1'b0;
        m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;

        tick();
        tick();
        checkOutput("arreadyInReset", 64'(s_arready), 64'd0);
        areset = 1'b0;
        tick();
        checkOutput("arreadyAfterReset", 64'(s_arready), 64'd1);
        checkOutput("rvalidAfterReset", 64'(s_rvalid), 64'd0);
        checkOutput("marvalidAfterReset", 64'(m_arvalid), 64'd0);
        checkOutput("mrreadyAfterReset", 64'(m_rready), 64'd0);
        checkOutput("cntAfterReset", 64'(dut.cnt), 64'd0);
        checkOutput("stateAfterReset", 64'(4'(dut.state)), 64'd1);

        // single read: AR latency, drain back to idle
        reqQ.push_back('{32'h0000_0010, 32'hA5A5_0001, 2'd0});
        waitIdle("singleRead", 50);
        tick();
        checkOutput("arLatency", 64'(lastMArCyc[0] - lastSArCyc), 64'd1);
        checkOutput("cntSingle", 64'(dut.cnt), 64'd0);
        checkOutput("stateSingle", 64'(4'(dut.state)), 64'd1);

        // table of single reads across the split boundary
        rDelay[0] = 2; rDelay[1] = 2;
        for (int i = 0; i < 7; i++) begin
            d0 = arCount[0];
            d1 = arCount[1];
            reqQ.push_back('{vecs[i].addr, vecs[i].data, vecs[i].resp});
            waitIdle("vecRead", 50);
            checkOutput("vecPort", 64'({arCount[1] - d1, arCount[0] - d0}),
                        vecs[i].port == 1 ? {32'd1, 32'd0} : {32'd0, 32'd1});
        end

        // four reads outstanding on port 0, fifth held in the AR register
        rDelay[0] = 1000;
        d0 = arCount[0];
        for (int i = 0; i < 5; i++) reqQ.push_back(modelReq(32'h0000_0100 + 32'(i) * 32'h10));
        for (int i = 0; i < 16; i++) tick();
        checkOutput("cntAtMax", 64'(dut.cnt), 64'd4);
        checkOutput("issuedAtMax", 64'(arCount[0] - d0), 64'd4);
        checkOutput("heldArvalid", 64'(m_arvalid), 64'd0);
        checkOutput("heldArready", 64'(s_arready), 64'd0);
        rDelay[0] = 0;
        waitIdle("maxOutstanding", 100);

        // region switch waits for port 0 to drain
        rDelay[0] = 10; rDelay[1] = 1;
        sawFlush   = 1'b0;
        doneBefore = rDone;
        reqQ.push_back(modelReq(32'h0000_0010));
        reqQ.push_back(modelReq(32'h8000_0010));
        waitIdle("flushSwitch", 100);
        checkOutput("sawFlush", 64'(sawFlush), 64'd1);
        checkOutput("port1AfterPort0R", 64'(arRDone[1] - doneBefore), 64'd1);

        // upstream backpressure holds the beat
        rDelay[0] = 0;
        sReadyEn  = 1'b0;
        reqQ.push_back(modelReq(32'h0000_0050));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = m_rvalid[0];
        end
        if (!seen) failNow("backpressureRvalid");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpRready", 64'(m_rready[0]), 64'd0);
            checkOutput("bpRvalid", 64'(s_rvalid), 64'd1);
            checkOutput("bpRdata", 64'(s_rdata), 64'h0000_0000_A5A5_0005);
            tick();
        end
        sReadyEn = 1'b1;
        waitIdle("backpressure", 50);

        // reset with two reads in flight, then a clean read
        rDelay[0] = 1000;
        reqQ.push_back(modelReq(32'h0000_0060));
        reqQ.push_back(modelReq(32'h0000_0070));
        for (int i = 0; i < 8; i++) tick();
        checkOutput("cntBeforeReset", 64'(dut.cnt), 64'd2);
        areset = 1'b1;
        resetBench();
        tick();
        areset = 1'b0;
        tick();
        checkOutput("cntMidReset", 64'(dut.cnt), 64'd0);
        checkOutput("stateMidReset", 64'(4'(dut.state)), 64'd1);
        checkOutput("marvalidMidReset", 64'(m_arvalid), 64'd0);
        checkOutput("rvalidMidReset", 64'(s_rvalid), 64'd0);
        rDelay[0] = 1;
        reqQ.push_back('{32'h0000_0080, 32'hA5A5_0008, 2'd0});
        waitIdle("afterReset", 50);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
